// File: rtl/ts_packet_mux.sv
// Four-channel round-robin TS packet multiplexer with one-cycle packet requests.
// Optional null-packet insertion on idle timeout is enabled by defining NULL_PKT_INSERT_EN.
module ts_packet_mux #(
  parameter int PKT_LEN      = 188,
  parameter int READ_LATENCY = 2,
  parameter int GUARD        = 4,
  parameter int NULL_TIMEOUT = 1024
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic [3:0] GOT_FULL_PACKET,
  input  logic [7:0] DATA_IN0,
  input  logic [7:0] DATA_IN1,
  input  logic [7:0] DATA_IN2,
  input  logic [7:0] DATA_IN3,
  output logic [3:0] GIVE_ME_ONE_PACKET,
  output logic [7:0] DATA_OUT,
  output logic       VALID_OUT,
  output logic       PSYNC_OUT,
  output logic [1:0] CH_OUT,
  output logic       NULL_OUT
);

  localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
  localparam logic [7:0] LAT_LOAD  = 8'(READ_LATENCY - 2);
  localparam logic [7:0] GAP_LOAD  = 8'(GUARD - 1);

  typedef enum logic [2:0] {
    SCAN,
    REQ,
    WAIT,
    XFER,
    GAP
`ifdef NULL_PKT_INSERT_EN
    , NULL
`endif
  } state_t;

  state_t     state_reg;
  logic [1:0] last_reg;
  logic [1:0] sel_reg;
  logic [7:0] byte_cnt_reg;
  logic [7:0] lat_cnt_reg;
  logic [7:0] gap_cnt_reg;
  logic [3:0] give_reg;
  logic [7:0] data_reg;
  logic       valid_reg;
  logic       psync_reg;
  logic [1:0] ch_reg;

  logic [7:0] data_in [4];
  logic [1:0] cand [4];
  logic [3:0] cand_hit;
  logic       found;
  logic [1:0] pick;

  assign data_in[0] = DATA_IN0;
  assign data_in[1] = DATA_IN1;
  assign data_in[2] = DATA_IN2;
  assign data_in[3] = DATA_IN3;

  // cand[0] is the channel right after the last one served, i.e. highest priority
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi]     = last_reg + 2'(gi + 1);
      assign cand_hit[gi] = GOT_FULL_PACKET[cand[gi]];
    end
  endgenerate

  always_comb begin
    found = |cand_hit;
    pick  = cand[3];
    for (int i = 2; i >= 0; i--) begin
      if (cand_hit[i]) pick = cand[i];
    end
  end

`ifdef NULL_PKT_INSERT_EN
  localparam int IDLE_W = $clog2(NULL_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(NULL_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              null_reg;
  logic [7:0]        null_byte;

  always_comb begin
    case (byte_cnt_reg)
      8'd0:    null_byte = 8'h47;
      8'd1:    null_byte = 8'h1F;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  end

  assign NULL_OUT = null_reg;
`else
  assign NULL_OUT = 1'b0;
`endif

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_reg    <= SCAN;
      last_reg     <= 2'd3;
      sel_reg      <= 2'd0;
      byte_cnt_reg <= 8'd0;
      lat_cnt_reg  <= 8'd0;
      gap_cnt_reg  <= 8'd0;
      give_reg     <= 4'b0000;
      data_reg     <= 8'd0;
      valid_reg    <= 1'b0;
      psync_reg    <= 1'b0;
      ch_reg       <= 2'd0;
`ifdef NULL_PKT_INSERT_EN
      idle_cnt_reg <= '0;
      null_reg     <= 1'b0;
`endif
    end else begin
      give_reg  <= 4'b0000;
      data_reg  <= 8'd0;
      valid_reg <= 1'b0;
      psync_reg <= 1'b0;
      ch_reg    <= 2'd0;
`ifdef NULL_PKT_INSERT_EN
      null_reg  <= 1'b0;
`endif
      case (state_reg)
        SCAN: begin
          if (found) begin
            sel_reg   <= pick;
            give_reg  <= 4'b0001 << pick;
            state_reg <= REQ;
`ifdef NULL_PKT_INSERT_EN
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == IDLE_LAST) begin
            idle_cnt_reg <= '0;
            byte_cnt_reg <= 8'd0;
            state_reg    <= NULL;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
`endif
          end
        end
        REQ: begin
          byte_cnt_reg <= 8'd0;
          if (READ_LATENCY <= 1) begin
            state_reg <= XFER;
          end else begin
            lat_cnt_reg <= LAT_LOAD;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_reg == 8'd0) state_reg <= XFER;
          else lat_cnt_reg <= lat_cnt_reg - 1'b1;
        end
        XFER: begin
          data_reg  <= data_in[sel_reg];
          valid_reg <= 1'b1;
          psync_reg <= (byte_cnt_reg == 8'd0);
          ch_reg    <= sel_reg;
          if (byte_cnt_reg == LAST_BYTE) begin
            last_reg     <= sel_reg;
            byte_cnt_reg <= 8'd0;
            gap_cnt_reg  <= GAP_LOAD;
            state_reg    <= (GUARD == 0) ? SCAN : GAP;
          end else begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == 8'd0) state_reg <= SCAN;
          else gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
`ifdef NULL_PKT_INSERT_EN
        // Null packets leave last_reg alone so round-robin fairness is unaffected
        NULL: begin
          data_reg  <= null_byte;
          valid_reg <= 1'b1;
          psync_reg <= (byte_cnt_reg == 8'd0);
          null_reg  <= 1'b1;
          if (byte_cnt_reg == LAST_BYTE) begin
            byte_cnt_reg <= 8'd0;
            gap_cnt_reg  <= GAP_LOAD;
            state_reg    <= (GUARD == 0) ? SCAN : GAP;
          end else begin
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
          end
        end
`endif
        default: state_reg <= SCAN;
      endcase
    end
  end

  assign GIVE_ME_ONE_PACKET = give_reg;
  assign DATA_OUT           = data_reg;
  assign VALID_OUT          = valid_reg;
  assign PSYNC_OUT          = psync_reg;
  assign CH_OUT             = ch_reg;

endmodule
